lsu_mem_seq: RTL and testbench

Sequencer between the LSU data path and a single-ported, variable-latency data-memory bus. Accepts one load/store per handshake and generates the word address, byte strobes and lane-aligned write data. Splits misaligned half/word accesses into two aligned word transactions. Merges and sign/zero-extends load data, then returns one response per request.

---
 rtl/singlecycle_pkg.sv | 35 +++
 rtl/lsu_mem_seq_if.sv | 42 ++++
 rtl/lsu_lane_align.sv | 46 ++++
 rtl/lsu_mem_seq.sv | 160 ++++++++++++++++
 tb/tb_lsu_mem_seq.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/singlecycle_pkg.sv
// Shared definitions for the LSU memory sequencer.
//   FUNCT3_WIDTH    : width of the LSU funct3 field
//   SZ_B/SZ_H/SZ_W  : access-size encodings in funct3[1:0]
//   lsu_seq_state_e : sequencer FSM states
//   size_mask()     : byte mask of an access before lane shifting
package singlecycle_pkg;

  localparam int unsigned FUNCT3_WIDTH = 3;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StReq0,
    StWait0,
    StReq1,
    StWait1,
    StRsp
  } lsu_seq_state_e;

  // Illegal size yields an empty mask.
  function automatic logic [3:0] size_mask(input logic [1:0] size);
    logic [3:0] mask;
    case (size)
      SZ_B:    mask = 4'b0001;
      SZ_H:    mask = 4'b0011;
      SZ_W:    mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/lsu_mem_seq_if.sv
// Bundle of the LSU request/response handshake and the data-memory bus.
// Signal names keep the sequencer's view: i_* flow into the sequencer, o_* out of it.
//   slave  : the sequencer side
//   master : the LSU data path plus the memory (drives i_*, observes o_*)
interface lsu_mem_seq_if #(
  parameter int unsigned ADDR_W = 32
);

  // LSU request / response
  logic                                    i_req_vld;
  logic                                    o_req_rdy;
  logic [singlecycle_pkg::FUNCT3_WIDTH-1:0] i_funct3;
  logic                                    i_we;
  logic [ADDR_W-1:0]                       i_addr;
  logic [31:0]                             i_st_data;
  logic                                    o_rsp_vld;
  logic                                    o_rsp_err;
  logic [31:0]                             o_ld_data;

  // Data-memory bus
  logic                                    o_mem_vld;
  logic                                    i_mem_rdy;
  logic [ADDR_W-1:0]                       o_mem_addr;
  logic                                    o_mem_we;
  logic [3:0]                              o_mem_strb;
  logic [31:0]                             o_mem_wdata;
  logic                                    i_mem_rvld;
  logic [31:0]                             i_mem_rdata;

  modport slave (
    input  i_req_vld, i_funct3, i_we, i_addr, i_st_data, i_mem_rdy, i_mem_rvld, i_mem_rdata,
    output o_req_rdy, o_rsp_vld, o_rsp_err, o_ld_data,
    output o_mem_vld, o_mem_addr, o_mem_we, o_mem_strb, o_mem_wdata
  );

  modport master (
    output i_req_vld, i_funct3, i_we, i_addr, i_st_data, i_mem_rdy, i_mem_rvld, i_mem_rdata,
    input  o_req_rdy, o_rsp_vld, o_rsp_err, o_ld_data,
    input  o_mem_vld, o_mem_addr, o_mem_we, o_mem_strb, o_mem_wdata
  );

endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane alignment for the LSU memory sequencer.
//   size_i, uns_i, lsb_i : access size, unsigned-load flag, byte offset in the word
//   st_data_i            : LSB-justified store data
//   rdata0_i, rdata1_i   : read data of the first and second word (second is 0 if unused)
//   strb8_o, wd64_o      : strobes / write data over two consecutive words
//   split_o              : access touches the second word
//   ld_data_o            : merged and extended load data
module lsu_lane_align
  import singlecycle_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  input  logic [1:0]  lsb_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] rdata0_i,
  input  logic [31:0] rdata1_i,
  output logic [7:0]  strb8_o,
  output logic [63:0] wd64_o,
  output logic        split_o,
  output logic [31:0] ld_data_o
);

  logic [55:0] merged;
  logic [31:0] raw;
  // Offsets never exceed 3, so the top byte of the second word never reaches the result.
  logic        unused_rdata1;

  assign unused_rdata1 = ^rdata1_i[31:24];

  always_comb begin
    strb8_o = {4'b0000, size_mask(size_i)} << lsb_i;
    wd64_o  = {32'b0, st_data_i} << {lsb_i, 3'b000};
    split_o = |strb8_o[7:4];

    merged  = {rdata1_i[23:0], rdata0_i} >> {lsb_i, 3'b000};
    raw     = merged[31:0];

    case (size_i)
      SZ_B:    ld_data_o = uns_i ? {24'b0, raw[7:0]}   : {{24{raw[7]}}, raw[7:0]};
      SZ_H:    ld_data_o = uns_i ? {16'b0, raw[15:0]}  : {{16{raw[15]}}, raw[15:0]};
      SZ_W:    ld_data_o = raw;
      default: ld_data_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_seq.sv
// LSU-to-data-memory sequencer. Takes one load/store per handshake, issues one or two
// aligned word transactions on a variable-latency bus, and returns one response.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus          : LSU request/response and memory bus (slave modport)
// All bus outputs are registered.
module lsu_mem_seq
  import singlecycle_pkg::*;
#(
  parameter bit          MISALIGN_EN = 1'b1,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  lsu_mem_seq_if.slave bus
);

  lsu_seq_state_e         state_q;
  logic [FUNCT3_WIDTH-1:0] funct3_q;
  logic                   we_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [31:0]            st_data_q;
  logic [31:0]            rdata0_q;

  logic                   in_idle;
  logic [FUNCT3_WIDTH-1:0] f3_sel;
  logic [1:0]             lsb_sel;
  logic [31:0]            st_sel;
  logic [31:0]            rd0_sel;
  logic [31:0]            rd1_sel;
  logic [7:0]             strb8;
  logic [63:0]            wd64;
  logic                   split;
  logic [31:0]            ld_data;
  logic                   illegal;
  logic                   misaligned;
  logic [ADDR_W-1:0]      base_in;
  logic [ADDR_W-1:0]      base_next;

  // In IDLE the aligner sees the incoming request so the first transaction can be
  // registered on the accepting edge; afterwards it sees the latched request.
  always_comb begin
    in_idle    = (state_q == StIdle);
    f3_sel     = in_idle ? bus.i_funct3        : funct3_q;
    lsb_sel    = in_idle ? bus.i_addr[1:0]     : addr_q[1:0];
    st_sel     = in_idle ? bus.i_st_data       : st_data_q;
    // Read data is merged on the completion cycle itself.
    rd0_sel    = (state_q == StWait0) ? bus.i_mem_rdata : rdata0_q;
    rd1_sel    = (state_q == StWait1) ? bus.i_mem_rdata : 32'b0;
    illegal    = (f3_sel[1:0] == 2'b11);
    misaligned = ((f3_sel[1:0] == SZ_H) && lsb_sel[0]) ||
                 ((f3_sel[1:0] == SZ_W) && (lsb_sel != 2'b00));
    base_in    = {bus.i_addr[ADDR_W-1:2], 2'b00};
    base_next  = {addr_q[ADDR_W-1:2], 2'b00} + ADDR_W'(4);
  end

  lsu_lane_align u_lane_align (
    .size_i    (f3_sel[1:0]),
    .uns_i     (f3_sel[2]),
    .lsb_i     (lsb_sel),
    .st_data_i (st_sel),
    .rdata0_i  (rd0_sel),
    .rdata1_i  (rd1_sel),
    .strb8_o   (strb8),
    .wd64_o    (wd64),
    .split_o   (split),
    .ld_data_o (ld_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q         <= StIdle;
      funct3_q        <= '0;
      we_q            <= 1'b0;
      addr_q          <= '0;
      st_data_q       <= '0;
      rdata0_q        <= '0;
      bus.o_req_rdy   <= 1'b1;
      bus.o_rsp_vld   <= 1'b0;
      bus.o_rsp_err   <= 1'b0;
      bus.o_ld_data   <= '0;
      bus.o_mem_vld   <= 1'b0;
      bus.o_mem_addr  <= '0;
      bus.o_mem_we    <= 1'b0;
      bus.o_mem_strb  <= '0;
      bus.o_mem_wdata <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          // o_req_rdy is always 1 here, so valid alone means accepted.
          if (bus.i_req_vld) begin
            funct3_q      <= bus.i_funct3;
            we_q          <= bus.i_we;
            addr_q        <= bus.i_addr;
            st_data_q     <= bus.i_st_data;
            bus.o_req_rdy <= 1'b0;
            if (illegal || (misaligned && !MISALIGN_EN)) begin
              state_q       <= StRsp;
              bus.o_rsp_vld <= 1'b1;
              bus.o_rsp_err <= 1'b1;
              bus.o_ld_data <= '0;
            end else begin
              state_q         <= StReq0;
              bus.o_mem_vld   <= 1'b1;
              bus.o_mem_addr  <= base_in;
              bus.o_mem_we    <= bus.i_we;
              bus.o_mem_strb  <= bus.i_we ? strb8[3:0] : 4'b1111;
              bus.o_mem_wdata <= bus.i_we ? wd64[31:0] : 32'b0;
            end
          end
        end
        StReq0: begin
          if (bus.i_mem_rdy) begin
            bus.o_mem_vld <= 1'b0;
            state_q       <= StWait0;
          end
        end
        StWait0: begin
          if (bus.i_mem_rvld) begin
            rdata0_q <= bus.i_mem_rdata;
            if (split) begin
              state_q         <= StReq1;
              bus.o_mem_vld   <= 1'b1;
              bus.o_mem_addr  <= base_next;
              bus.o_mem_strb  <= we_q ? strb8[7:4] : 4'b1111;
              bus.o_mem_wdata <= we_q ? wd64[63:32] : 32'b0;
            end else begin
              state_q       <= StRsp;
              bus.o_rsp_vld <= 1'b1;
              bus.o_rsp_err <= 1'b0;
              bus.o_ld_data <= we_q ? 32'b0 : ld_data;
            end
          end
        end
        StReq1: begin
          if (bus.i_mem_rdy) begin
            bus.o_mem_vld <= 1'b0;
            state_q       <= StWait1;
          end
        end
        StWait1: begin
          if (bus.i_mem_rvld) begin
            state_q       <= StRsp;
            bus.o_rsp_vld <= 1'b1;
            bus.o_rsp_err <= 1'b0;
            bus.o_ld_data <= we_q ? 32'b0 : ld_data;
          end
        end
        StRsp: begin
          state_q       <= StIdle;
          bus.o_rsp_vld <= 1'b0;
          bus.o_rsp_err <= 1'b0;
          bus.o_ld_data <= '0;
          bus.o_req_rdy <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_seq.sv
// Bench for lsu_mem_seq: directed requests push expected responses and expected memory
// transactions into queues; memory-model and monitor processes pop and compare.
module tb_lsu_mem_seq;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          lat;
    int          acc;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          stall;
  } mem_t;

  logic i_clk = 1'b0;
  logic rst   = 1'b1;
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   rsp_delay = 1;
  int   n_acc0 = 0;
  bit   mem1_seen = 1'b0;

  rsp_t rq0[$];
  rsp_t rq1[$];
  mem_t mq0[$];

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  lsu_mem_seq_if #(.ADDR_W(32)) bus0 ();
  lsu_mem_seq_if #(.ADDR_W(32)) bus1 ();

  lsu_mem_seq #(.MISALIGN_EN(1'b1), .ADDR_W(32)) u_dut0 (
    .i_clk (i_clk),
    .i_rst (rst),
    .bus   (bus0)
  );

  lsu_mem_seq #(.MISALIGN_EN(1'b0), .ADDR_W(32)) u_dut1 (
    .i_clk (i_clk),
    .i_rst (rst),
    .bus   (bus1)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input int sel, input string name);
    if (sel == 0) begin
      check({name, "_ctrl"}, {bus0.o_req_rdy, bus0.o_rsp_vld, bus0.o_rsp_err, bus0.o_mem_vld,
                              bus0.o_mem_we, bus0.o_mem_strb}, 9'b1_0000_0000);
      check({name, "_data"}, {bus0.o_ld_data, bus0.o_mem_addr, bus0.o_mem_wdata}, 96'b0);
    end else begin
      check({name, "_ctrl"}, {bus1.o_req_rdy, bus1.o_rsp_vld, bus1.o_rsp_err, bus1.o_mem_vld,
                              bus1.o_mem_we, bus1.o_mem_strb}, 9'b1_0000_0000);
      check({name, "_data"}, {bus1.o_ld_data, bus1.o_mem_addr, bus1.o_mem_wdata}, 96'b0);
    end
  endtask

  task automatic mem_exp(input logic [31:0] addr, input logic we, input logic [3:0] strb,
                         input logic [31:0] wdata, input logic [31:0] rdata, input int stall);
    mem_t m;
    m.addr = addr; m.we = we; m.strb = strb; m.wdata = wdata; m.rdata = rdata; m.stall = stall;
    mq0.push_back(m);
  endtask

  // Called on a negedge; returns on the negedge after the accepting edge.
  task automatic issue(input int sel, input logic [2:0] f3, input logic we,
                       input logic [31:0] addr, input logic [31:0] sd, input logic eerr,
                       input logic [31:0] edata, input int elat, input bit track);
    int   n;
    rsp_t r;
    n = 0;
    while (((sel == 0) ? bus0.o_req_rdy : bus1.o_req_rdy) !== 1'b1 && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 200) begin
      n_vec++;
      n_err++;
      $display("FAIL req_rdy_timeout: got 0 required 1 within 200 cycles");
      return;
    end
    if (sel == 0) begin
      bus0.i_req_vld = 1'b1; bus0.i_funct3 = f3; bus0.i_we = we;
      bus0.i_addr = addr; bus0.i_st_data = sd;
    end else begin
      bus1.i_req_vld = 1'b1; bus1.i_funct3 = f3; bus1.i_we = we;
      bus1.i_addr = addr; bus1.i_st_data = sd;
    end
    r.err = eerr; r.data = edata; r.lat = elat; r.acc = cyc;
    if (track) begin
      if (sel == 0) rq0.push_back(r);
      else          rq1.push_back(r);
    end
    @(negedge i_clk);
    bus0.i_req_vld = 1'b0;
    bus1.i_req_vld = 1'b0;
  endtask

  // Memory model for dut0: checks each accepted transaction, holds fields stable under
  // stall, and completes rsp_delay cycles after acceptance.
  initial begin : mem0
    int          pend;
    int          stall;
    bit          busy;
    logic [31:0] pend_data;
    logic [68:0] snap;
    mem_t        m;
    pend = 0; stall = 0; busy = 1'b0; pend_data = '0; snap = '0;
    bus0.i_mem_rdy = 1'b0; bus0.i_mem_rvld = 1'b0; bus0.i_mem_rdata = '0;
    forever begin
      @(negedge i_clk);
      bus0.i_mem_rvld  = 1'b0;
      bus0.i_mem_rdata = '0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus0.i_mem_rvld  = 1'b1;
          bus0.i_mem_rdata = pend_data;
        end
      end
      bus0.i_mem_rdy = 1'b0;
      if (bus0.o_mem_vld === 1'b1) begin
        if (!busy) begin
          busy  = 1'b1;
          snap  = {bus0.o_mem_addr, bus0.o_mem_we, bus0.o_mem_strb, bus0.o_mem_wdata};
          stall = (mq0.size() > 0) ? mq0[0].stall : 0;
        end else begin
          check("mem_stable", {bus0.o_mem_addr, bus0.o_mem_we, bus0.o_mem_strb,
                               bus0.o_mem_wdata}, snap);
        end
        if (stall > 0) begin
          stall--;
        end else begin
          bus0.i_mem_rdy = 1'b1;
          busy = 1'b0;
          n_acc0++;
          if (mq0.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL mem_unexpected: got addr 0x%0h required no access", bus0.o_mem_addr);
            pend_data = '0;
          end else begin
            m = mq0.pop_front();
            check("mem_addr", bus0.o_mem_addr, m.addr);
            check("mem_we", bus0.o_mem_we, m.we);
            check("mem_strb", bus0.o_mem_strb, m.strb);
            check("mem_wdata", bus0.o_mem_wdata, m.wdata);
            pend_data = m.rdata;
          end
          pend = rsp_delay;
        end
      end
    end
  end

  initial begin : mon0
    rsp_t r;
    forever begin
      @(negedge i_clk);
      if (bus0.o_rsp_vld === 1'b1) begin
        if (rq0.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rsp0_unexpected: got err=%0b data=0x%0h required no response",
                   bus0.o_rsp_err, bus0.o_ld_data);
        end else begin
          r = rq0.pop_front();
          check("rsp0_err", bus0.o_rsp_err, r.err);
          check("rsp0_data", bus0.o_ld_data, r.data);
          check("rsp0_latency", cyc - r.acc, r.lat);
        end
      end
    end
  end

  initial begin : mon1
    rsp_t r;
    bus1.i_mem_rdy = 1'b1; bus1.i_mem_rvld = 1'b0; bus1.i_mem_rdata = '0;
    forever begin
      @(negedge i_clk);
      if (bus1.o_mem_vld === 1'b1) mem1_seen = 1'b1;
      if (bus1.o_rsp_vld === 1'b1) begin
        if (rq1.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rsp1_unexpected: got err=%0b data=0x%0h required no response",
                   bus1.o_rsp_err, bus1.o_ld_data);
        end else begin
          r = rq1.pop_front();
          check("rsp1_err", bus1.o_rsp_err, r.err);
          check("rsp1_data", bus1.o_ld_data, r.data);
          check("rsp1_latency", cyc - r.acc, r.lat);
        end
      end
    end
  end

  initial begin : stim
    int n;
    int n0;
    bus0.i_req_vld = 1'b0; bus0.i_funct3 = '0; bus0.i_we = 1'b0;
    bus0.i_addr = '0; bus0.i_st_data = '0;
    bus1.i_req_vld = 1'b0; bus1.i_funct3 = '0; bus1.i_we = 1'b0;
    bus1.i_addr = '0; bus1.i_st_data = '0;
    rst = 1'b1;
    repeat (2) @(negedge i_clk);
    check_idle(0, "reset0");
    check_idle(1, "reset1");
    rst = 1'b0;
    @(negedge i_clk);

    // SB into byte lane 2
    mem_exp(32'h100, 1'b1, 4'b0100, 32'hCCDD_0000, 32'h0, 0);
    issue(0, 3'b000, 1'b1, 32'h102, 32'hAABB_CCDD, 1'b0, 32'h0, 3, 1'b1);
    // LH / LHU from upper half
    mem_exp(32'h204, 1'b0, 4'b1111, 32'h0, 32'h8001_1234, 0);
    issue(0, 3'b001, 1'b0, 32'h206, 32'h0, 1'b0, 32'hFFFF_8001, 3, 1'b1);
    mem_exp(32'h204, 1'b0, 4'b1111, 32'h0, 32'h8001_1234, 0);
    issue(0, 3'b101, 1'b0, 32'h206, 32'h0, 1'b0, 32'h0000_8001, 3, 1'b1);
    // LB / LBU from top lane
    mem_exp(32'h200, 1'b0, 4'b1111, 32'h0, 32'h8012_3456, 0);
    issue(0, 3'b000, 1'b0, 32'h203, 32'h0, 1'b0, 32'hFFFF_FF80, 3, 1'b1);
    mem_exp(32'h200, 1'b0, 4'b1111, 32'h0, 32'h8012_3456, 0);
    issue(0, 3'b100, 1'b0, 32'h203, 32'h0, 1'b0, 32'h0000_0080, 3, 1'b1);
    // Split LW
    mem_exp(32'h300, 1'b0, 4'b1111, 32'h0, 32'h1122_3344, 0);
    mem_exp(32'h304, 1'b0, 4'b1111, 32'h0, 32'h5566_7788, 0);
    issue(0, 3'b010, 1'b0, 32'h303, 32'h0, 1'b0, 32'h6677_8811, 5, 1'b1);
    // Split SW with the second transaction stalled 3 cycles
    mem_exp(32'h104, 1'b1, 4'b1100, 32'hBEEF_0000, 32'h0, 0);
    mem_exp(32'h108, 1'b1, 4'b0011, 32'h0000_DEAD, 32'h0, 3);
    issue(0, 3'b010, 1'b1, 32'h106, 32'hDEAD_BEEF, 1'b0, 32'h0, 8, 1'b1);
    // Split LW wrapping the address space
    mem_exp(32'hFFFF_FFFC, 1'b0, 4'b1111, 32'h0, 32'hAABB_CCDD, 0);
    mem_exp(32'h0000_0000, 1'b0, 4'b1111, 32'h0, 32'h1122_3344, 0);
    issue(0, 3'b010, 1'b0, 32'hFFFF_FFFE, 32'h0, 1'b0, 32'h3344_AABB, 5, 1'b1);
    // Illegal sizes, no memory access
    issue(0, 3'b011, 1'b0, 32'h100, 32'h0, 1'b1, 32'h0, 1, 1'b1);
    issue(0, 3'b111, 1'b1, 32'h100, 32'h1234_5678, 1'b1, 32'h0, 1, 1'b1);
    // Misalignment disallowed
    issue(1, 3'b010, 1'b0, 32'h101, 32'h0, 1'b1, 32'h0, 1, 1'b1);
    issue(1, 3'b001, 1'b0, 32'h101, 32'h0, 1'b1, 32'h0, 1, 1'b1);
    issue(1, 3'b011, 1'b0, 32'h100, 32'h0, 1'b1, 32'h0, 1, 1'b1);

    // Reset while waiting for the second completion of a split load
    rsp_delay = 3;
    n0 = n_acc0;
    mem_exp(32'h300, 1'b0, 4'b1111, 32'h0, 32'h1122_3344, 0);
    mem_exp(32'h304, 1'b0, 4'b1111, 32'h0, 32'h5566_7788, 0);
    issue(0, 3'b010, 1'b0, 32'h303, 32'h0, 1'b0, 32'h0, 0, 1'b0);
    n = 0;
    while (n_acc0 < n0 + 2 && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 100) begin
      n_vec++;
      n_err++;
      $display("FAIL split_accept_timeout: got %0d accepts required %0d", n_acc0 - n0, 2);
    end
    @(negedge i_clk);
    rst = 1'b1;
    @(negedge i_clk);
    rst = 1'b0;
    rsp_delay = 1;
    check_idle(0, "midop_reset");
    repeat (4) @(negedge i_clk);
    check_idle(0, "late_rvld_ignored");
    mem_exp(32'h200, 1'b1, 4'b1111, 32'h1234_5678, 32'h0, 0);
    issue(0, 3'b010, 1'b1, 32'h200, 32'h1234_5678, 1'b0, 32'h0, 3, 1'b1);

    n = 0;
    while ((rq0.size() > 0 || rq1.size() > 0 || mq0.size() > 0) && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 200) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d/%0d/%0d pending required 0/0/0",
               rq0.size(), rq1.size(), mq0.size());
    end
    repeat (3) @(negedge i_clk);
    check("dut1_no_mem_access", mem1_seen, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
